pwm_gen_from_count: RTL and testbench
=====================================

Name: pwm_gen_from_count

Overview:
Downstream consumer of the 3-bit synchronous T-flip-flop up counter. Takes the free-running count and produces four things:
- a registered PWM output;
- a one-cycle wrap pulse;
- a saturating wrap (period) counter;
- a sticky sequence-error flag that checks the count advances by exactly +1 every cycle.

The duty value is loaded through a valid/ready handshake. It is double-buffered and committed only at a count wrap, so a period is never glitched.

Parameters:
- WIDTH, 3, width of count_in; PWM period is 2^WIDTH cycles.
- WRAP_CNT_W, 8, width of wrap_cnt_o.

Ports:
- clk  input  1  rising-edge clock, shared with the counter.
- reset  input  1  asynchronous, active-high reset.
- count_in  input  WIDTH  counter value, sampled every rising edge.
- duty_i  input  WIDTH+1  requested high-cycles per period, legal range 0..2^WIDTH.
- duty_valid_i  input  1  duty_i is valid.
- duty_ready_o  output  1  block can accept a duty value.
- err_clr_i  input  1  clears seq_err_o.
- pwm_o  output  1  registered PWM output.
- wrap_o  output  1  one-cycle pulse marking start of a period.
- wrap_cnt_o  output  WRAP_CNT_W  number of wraps seen, saturating.
- seq_err_o  output  1  sticky count-sequence error.

Behaviour:
Reset values:
- pwm_o=0, wrap_o=0, wrap_cnt_o=0, seq_err_o=0, duty_ready_o=1.
- Internal: duty_active=0, pending_valid=0, prev_valid=0, prev_count=0.
- Reset asserted mid-operation discards any pending duty immediately.

Sampling and latency:
- All outputs are registered.
- Each output reflects count_in sampled at edge N and appears after edge N (1-cycle latency).

Wrap detection:
- wrap = prev_valid AND prev_count == 2^WIDTH-1 AND count_in == 0.
- wrap_o follows wrap, one cycle high.
- The first sample after reset never produces a wrap.

Wrap counter:
- wrap_cnt_o increments on each wrap.
- Saturates at 2^WRAP_CNT_W-1; no wrap-around.

Sequence check:
- With prev_valid=1, error = count_in != (prev_count+1) mod 2^WIDTH.
- Error sets seq_err_o; the flag stays set until err_clr_i.
- If error and err_clr_i occur in the same cycle, set wins.
- prev_valid becomes 1 after the first post-reset edge; the first sample is never checked.

Duty handshake:
- Transfer occurs when duty_valid_i && duty_ready_o.
- On transfer:
  - pending <= min(duty_i, 2^WIDTH);
  - pending_valid <= 1;
  - duty_ready_o <= 0.
- duty_ready_o = !pending_valid (registered).
- While duty_ready_o=0, duty_i is ignored.

Commit:
- Commit happens on the edge where count_in == 0 is sampled with pending_valid=1. Wrap-qualification is not required, so the very first 0 after reset also commits.
- On commit: duty_active <= pending, pending_valid <= 0, so duty_ready_o=1 next cycle.
- A transfer in the same cycle as a commit edge is impossible, because ready=0 while pending.
- A transfer on a count==0 edge with an empty pending register waits for the next 0.

PWM:
- pwm_o <= (count_in < duty_eff).
- duty_eff = pending when committing on this edge, else duty_active.
- duty 0 gives pwm_o constantly 0.
- duty 2^WIDTH gives pwm_o constantly 1.
- All arithmetic is unsigned, WIDTH+1 bits for the compare.

Decomposition:
- Shared package counter_pkg holds:
  - constant CNT_WIDTH=3;
  - constant CNT_MAX=2^CNT_WIDTH-1;
  - typedef cnt_t (CNT_WIDTH bits);
  - typedef duty_t (CNT_WIDTH+1 bits).
- One natural sub-module, count_seq_checker, owns prev_count, prev_valid, wrap detection and the sticky seq_err_o.
- The top level owns the duty double-buffer, the PWM compare and wrap_cnt_o.

Test Plan:
- Reset, then free-running counter 0..7 repeated, no duty load:
  - pwm_o=0 throughout;
  - wrap_o pulses once every 8 cycles, first pulse one cycle after count_in goes 7->0;
  - wrap_cnt_o = 3 after 3 wraps;
  - seq_err_o=0.
- Load duty_i=3 with valid held high while count=5:
  - duty_ready_o drops next cycle;
  - value commits on the count=0 sample;
  - pwm_o is high for 3 cycles (counts 0,1,2) per period from then;
  - duty_ready_o returns to 1.
- Corner duties:
  - duty_i=0 gives pwm_o constantly 0;
  - duty_i=8 gives pwm_o constantly 1;
  - duty_i=15 is clamped, so pwm_o is constantly 1.
- Force count_in to jump 2->5:
  - seq_err_o=1 one cycle later and stays 1;
  - pulsing err_clr_i clears it;
  - a jump 5->7 coinciding with err_clr_i leaves seq_err_o=1.
- Run 300 wraps with WRAP_CNT_W=8: wrap_cnt_o saturates at 255.
- Assert reset with a duty pending (loaded at count=3):
  - all outputs return to reset values;
  - after release, duty_active=0, so pwm_o stays 0 through the next period;
  - the first post-reset sample produces no wrap and no error.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and constants for the 3-bit up counter and the blocks that consume its count.
package counter_pkg;

  localparam int CNT_WIDTH = 3;
  localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

  typedef logic [CNT_WIDTH-1:0] cnt_t;
  typedef logic [CNT_WIDTH:0]   duty_t;

endpackage

// File: rtl/count_seq_checker.sv
// Tracks the previous count sample to detect period wraps and to flag any step that is not +1.
module count_seq_checker #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_err_clr,
  output logic             o_wrap,
  output logic             o_wrap_pulse,
  output logic             o_seq_err
);

  logic [WIDTH-1:0] r_prev_count;
  logic             r_prev_valid;
  logic             r_wrap_pulse;
  logic             r_seq_err;
  logic [WIDTH-1:0] w_expected;
  logic             w_wrap;
  logic             w_step_err;

  // The very first sample after reset has no history, so it can neither wrap nor fail the step check.
  assign w_expected = r_prev_count + WIDTH'(1'b1);
  assign w_wrap     = r_prev_valid && (r_prev_count == '1) && (i_count == '0);
  assign w_step_err = r_prev_valid && (i_count != w_expected);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_count <= '0;
      r_prev_valid <= 1'b0;
      r_wrap_pulse <= 1'b0;
    end else begin
      r_prev_count <= i_count;
      r_prev_valid <= 1'b1;
      r_wrap_pulse <= w_wrap;
    end
  end

  // A fresh error outranks a simultaneous clear so no bad step is ever lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seq_err <= 1'b0;
    end else if (w_step_err) begin
      r_seq_err <= 1'b1;
    end else if (i_err_clr) begin
      r_seq_err <= 1'b0;
    end
  end

  assign o_wrap       = w_wrap;
  assign o_wrap_pulse = r_wrap_pulse;
  assign o_seq_err    = r_seq_err;

endmodule

// File: rtl/pwm_gen_from_count.sv
// PWM generator driven by an external free-running count; duty is double-buffered and
// committed only when the count returns to zero so a period is never glitched.
module pwm_gen_from_count
  import counter_pkg::*;
#(
  parameter int WIDTH      = CNT_WIDTH,
  parameter int WRAP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      count_in,
  input  logic [WIDTH:0]        duty_i,
  input  logic                  duty_valid_i,
  output logic                  duty_ready_o,
  input  logic                  err_clr_i,
  output logic                  pwm_o,
  output logic                  wrap_o,
  output logic [WRAP_CNT_W-1:0] wrap_cnt_o,
  output logic                  seq_err_o
);

  localparam logic [WIDTH:0] DUTY_MAX = {1'b1, {WIDTH{1'b0}}};

  logic [WIDTH:0]        r_pending;
  logic                  r_pending_valid;
  logic [WIDTH:0]        r_duty_active;
  logic                  r_pwm;
  logic [WRAP_CNT_W-1:0] r_wrap_cnt;

  logic                  w_xfer;
  logic                  w_commit;
  logic [WIDTH:0]        w_duty_clamped;
  logic [WIDTH:0]        w_duty_eff;
  logic                  w_wrap;
  logic                  w_wrap_pulse;
  logic                  w_seq_err;

  count_seq_checker #(
    .WIDTH(WIDTH)
  ) u_seq_checker (
    .clk         (clk),
    .reset       (reset),
    .i_count     (count_in),
    .i_err_clr   (err_clr_i),
    .o_wrap      (w_wrap),
    .o_wrap_pulse(w_wrap_pulse),
    .o_seq_err   (w_seq_err)
  );

  // Commit is keyed on count==0 alone, so the first zero after reset also loads a pending duty.
  assign w_xfer         = duty_valid_i && !r_pending_valid;
  assign w_commit       = r_pending_valid && (count_in == '0);
  assign w_duty_clamped = (duty_i > DUTY_MAX) ? DUTY_MAX : duty_i;
  assign w_duty_eff     = w_commit ? r_pending : r_duty_active;

  // Ready is simply the inverse of the pending flag, so a transfer and a commit can never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending       <= '0;
      r_pending_valid <= 1'b0;
      r_duty_active   <= '0;
    end else begin
      if (w_xfer) begin
        r_pending       <= w_duty_clamped;
        r_pending_valid <= 1'b1;
      end else if (w_commit) begin
        r_pending_valid <= 1'b0;
      end
      if (w_commit) begin
        r_duty_active <= r_pending;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pwm      <= 1'b0;
      r_wrap_cnt <= '0;
    end else begin
      r_pwm <= ({1'b0, count_in} < w_duty_eff);
      if (w_wrap && (r_wrap_cnt != '1)) begin
        r_wrap_cnt <= r_wrap_cnt + WRAP_CNT_W'(1'b1);
      end
    end
  end

  assign duty_ready_o = !r_pending_valid;
  assign pwm_o        = r_pwm;
  assign wrap_o       = w_wrap_pulse;
  assign wrap_cnt_o   = r_wrap_cnt;
  assign seq_err_o    = w_seq_err;

endmodule

// File: tb/tb_pwm_gen_from_count.sv
// Directed bench for pwm_gen_from_count: the bench plays the role of the upstream counter.
module tb_pwm_gen_from_count;
  import counter_pkg::*;

  localparam int WIDTH      = CNT_WIDTH;
  localparam int WRAP_CNT_W = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [WIDTH-1:0]      count_in;
  logic [WIDTH:0]        duty_i;
  logic                  duty_valid_i;
  logic                  duty_ready_o;
  logic                  err_clr_i;
  logic                  pwm_o;
  logic                  wrap_o;
  logic [WRAP_CNT_W-1:0] wrap_cnt_o;
  logic                  seq_err_o;

  int passCount  = 0;
  int checkCount = 0;
  int curCount   = 0;
  bit haveLast   = 1'b0;
  int benchWraps = 0;

  pwm_gen_from_count #(
    .WIDTH     (WIDTH),
    .WRAP_CNT_W(WRAP_CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .count_in    (count_in),
    .duty_i      (duty_i),
    .duty_valid_i(duty_valid_i),
    .duty_ready_o(duty_ready_o),
    .err_clr_i   (err_clr_i),
    .pwm_o       (pwm_o),
    .wrap_o      (wrap_o),
    .wrap_cnt_o  (wrap_cnt_o),
    .seq_err_o   (seq_err_o)
  );

  always #5 clk = ~clk;

  // Presents one count sample, then returns 1ns after the edge that captured it.
  task automatic drive(input int c);
    if (haveLast && curCount == CNT_MAX && c == 0) benchWraps++;
    count_in = cnt_t'(c);
    curCount = c;
    haveLast = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) drive((curCount + 1) % (CNT_MAX + 1));
  endtask

  task automatic test_reset;
    reset = 1'b1;
    count_in = '0;
    duty_i = '0;
    duty_valid_i = 1'b0;
    err_clr_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkCount++; if (pwm_o !== 1'b0) $display("[TB] FAIL reset_pwm: got %b expected 0", pwm_o); else passCount++;
    checkCount++; if (wrap_o !== 1'b0) $display("[TB] FAIL reset_wrap: got %b expected 0", wrap_o); else passCount++;
    checkCount++; if (wrap_cnt_o !== 8'd0) $display("[TB] FAIL reset_wrap_cnt: got %0d expected 0", wrap_cnt_o); else passCount++;
    checkCount++; if (seq_err_o !== 1'b0) $display("[TB] FAIL reset_seq_err: got %b expected 0", seq_err_o); else passCount++;
    checkCount++; if (duty_ready_o !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", duty_ready_o); else passCount++;
    reset = 1'b0;
    haveLast = 1'b0;
  endtask

  task automatic test_free_run;
    for (int i = 0; i <= 24; i++) begin
      drive(i % 8);
      checkCount++; if (wrap_o !== ((i > 0) && (i % 8 == 0))) $display("[TB] FAIL free_wrap[%0d]: got %b expected %b", i, wrap_o, ((i > 0) && (i % 8 == 0))); else passCount++;
      checkCount++; if (pwm_o !== 1'b0) $display("[TB] FAIL free_pwm[%0d]: got %b expected 0", i, pwm_o); else passCount++;
      checkCount++; if (seq_err_o !== 1'b0) $display("[TB] FAIL free_seq_err[%0d]: got %b expected 0", i, seq_err_o); else passCount++;
    end
    checkCount++; if (wrap_cnt_o !== 8'd3) $display("[TB] FAIL free_wrap_cnt: got %0d expected 3", wrap_cnt_o); else passCount++;
  endtask

  task automatic test_duty_load;
    while (curCount != 4) advance(1);
    duty_i = 5'd3;
    duty_i = 4'd3;
    duty_valid_i = 1'b1;
    drive(5);
    checkCount++; if (duty_ready_o !== 1'b0) $display("[TB] FAIL load_ready_drop: got %b expected 0", duty_ready_o); else passCount++;
    duty_i = 4'd6;
    drive(6);
    checkCount++; if (duty_ready_o !== 1'b0) $display("[TB] FAIL load_ready_held: got %b expected 0", duty_ready_o); else passCount++;
    checkCount++; if (pwm_o !== 1'b0) $display("[TB] FAIL load_pwm_before6: got %b expected 0", pwm_o); else passCount++;
    duty_valid_i = 1'b0;
    drive(7);
    checkCount++; if (pwm_o !== 1'b0) $display("[TB] FAIL load_pwm_before7: got %b expected 0", pwm_o); else passCount++;
    for (int k = 0; k < 16; k++) begin
      drive(k % 8);
      checkCount++; if (pwm_o !== ((k % 8) < 3)) $display("[TB] FAIL load_pwm[%0d]: got %b expected %b", k, pwm_o, ((k % 8) < 3)); else passCount++;
      checkCount++; if (duty_ready_o !== 1'b1) $display("[TB] FAIL load_ready_back[%0d]: got %b expected 1", k, duty_ready_o); else passCount++;
    end
  endtask

  task automatic test_corner_duties;
    int duties [3] = '{0, 8, 15};
    int effDuty;
    for (int j = 0; j < 3; j++) begin
      effDuty = (duties[j] > 8) ? 8 : duties[j];
      duty_i = 4'(duties[j]);
      duty_valid_i = 1'b1;
      advance(1);
      duty_valid_i = 1'b0;
      checkCount++; if (duty_ready_o !== 1'b0) $display("[TB] FAIL corner_ready[%0d]: got %b expected 0", duties[j], duty_ready_o); else passCount++;
      while (curCount != 7) advance(1);
      for (int k = 0; k < 8; k++) begin
        drive(k);
        checkCount++; if (pwm_o !== (k < effDuty)) $display("[TB] FAIL corner_pwm[d%0d,c%0d]: got %b expected %b", duties[j], k, pwm_o, (k < effDuty)); else passCount++;
      end
    end
  endtask

  task automatic test_seq_err;
    while (curCount != 2) advance(1);
    drive(5);
    checkCount++; if (seq_err_o !== 1'b1) $display("[TB] FAIL seq_jump_set: got %b expected 1", seq_err_o); else passCount++;
    checkCount++; if (wrap_o !== 1'b0) $display("[TB] FAIL seq_jump_wrap: got %b expected 0", wrap_o); else passCount++;
    drive(6);
    checkCount++; if (seq_err_o !== 1'b1) $display("[TB] FAIL seq_sticky: got %b expected 1", seq_err_o); else passCount++;
    err_clr_i = 1'b1;
    drive(7);
    err_clr_i = 1'b0;
    checkCount++; if (seq_err_o !== 1'b0) $display("[TB] FAIL seq_clear: got %b expected 0", seq_err_o); else passCount++;
    drive(0);
    checkCount++; if (wrap_o !== 1'b1) $display("[TB] FAIL seq_wrap_after_clear: got %b expected 1", wrap_o); else passCount++;
    while (curCount != 3) advance(1);
    drive(0);
    checkCount++; if (seq_err_o !== 1'b1) $display("[TB] FAIL seq_jump_to_zero: got %b expected 1", seq_err_o); else passCount++;
    checkCount++; if (wrap_o !== 1'b0) $display("[TB] FAIL seq_false_wrap: got %b expected 0", wrap_o); else passCount++;
    err_clr_i = 1'b1;
    drive(1);
    err_clr_i = 1'b0;
    checkCount++; if (seq_err_o !== 1'b0) $display("[TB] FAIL seq_clear2: got %b expected 0", seq_err_o); else passCount++;
    while (curCount != 5) advance(1);
    err_clr_i = 1'b1;
    drive(7);
    err_clr_i = 1'b0;
    checkCount++; if (seq_err_o !== 1'b1) $display("[TB] FAIL seq_set_wins: got %b expected 1", seq_err_o); else passCount++;
    drive(0);
    checkCount++; if (seq_err_o !== 1'b1) $display("[TB] FAIL seq_sticky2: got %b expected 1", seq_err_o); else passCount++;
    err_clr_i = 1'b1;
    drive(1);
    err_clr_i = 1'b0;
    checkCount++; if (seq_err_o !== 1'b0) $display("[TB] FAIL seq_clear3: got %b expected 0", seq_err_o); else passCount++;
  endtask

  task automatic test_saturation;
    for (int p = 0; p < 300; p++) begin
      advance(8);
      if (p == 99) begin
        checkCount++; if (wrap_cnt_o !== 8'(benchWraps)) $display("[TB] FAIL sat_midway: got %0d expected %0d", wrap_cnt_o, benchWraps); else passCount++;
      end
    end
    checkCount++; if (wrap_cnt_o !== 8'd255) $display("[TB] FAIL sat_final: got %0d expected 255", wrap_cnt_o); else passCount++;
    while (curCount != 7) advance(1);
    drive(0);
    checkCount++; if (wrap_o !== 1'b1) $display("[TB] FAIL sat_wrap_pulse: got %b expected 1", wrap_o); else passCount++;
    checkCount++; if (wrap_cnt_o !== 8'd255) $display("[TB] FAIL sat_hold: got %0d expected 255", wrap_cnt_o); else passCount++;
  endtask

  task automatic test_reset_pending;
    while (curCount != 2) advance(1);
    duty_i = 4'd5;
    duty_valid_i = 1'b1;
    drive(3);
    duty_valid_i = 1'b0;
    checkCount++; if (duty_ready_o !== 1'b0) $display("[TB] FAIL rst_pend_ready: got %b expected 0", duty_ready_o); else passCount++;
    checkCount++; if (pwm_o !== 1'b1) $display("[TB] FAIL rst_pre_pwm: got %b expected 1", pwm_o); else passCount++;
    reset = 1'b1;
    #1;
    checkCount++; if (pwm_o !== 1'b0) $display("[TB] FAIL rst_mid_pwm: got %b expected 0", pwm_o); else passCount++;
    checkCount++; if (wrap_o !== 1'b0) $display("[TB] FAIL rst_mid_wrap: got %b expected 0", wrap_o); else passCount++;
    checkCount++; if (wrap_cnt_o !== 8'd0) $display("[TB] FAIL rst_mid_wrap_cnt: got %0d expected 0", wrap_cnt_o); else passCount++;
    checkCount++; if (seq_err_o !== 1'b0) $display("[TB] FAIL rst_mid_seq_err: got %b expected 0", seq_err_o); else passCount++;
    checkCount++; if (duty_ready_o !== 1'b1) $display("[TB] FAIL rst_mid_ready: got %b expected 1", duty_ready_o); else passCount++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    haveLast = 1'b0;
    benchWraps = 0;
    drive(4);
    checkCount++; if (seq_err_o !== 1'b0) $display("[TB] FAIL rst_first_no_err: got %b expected 0", seq_err_o); else passCount++;
    checkCount++; if (wrap_o !== 1'b0) $display("[TB] FAIL rst_first_no_wrap: got %b expected 0", wrap_o); else passCount++;
    while (curCount != 7) advance(1);
    for (int k = 0; k < 8; k++) begin
      drive(k);
      checkCount++; if (pwm_o !== 1'b0) $display("[TB] FAIL rst_pwm_off[%0d]: got %b expected 0", k, pwm_o); else passCount++;
      checkCount++; if (wrap_o !== (k == 0)) $display("[TB] FAIL rst_wrap[%0d]: got %b expected %b", k, wrap_o, (k == 0)); else passCount++;
    end
    checkCount++; if (wrap_cnt_o !== 8'd1) $display("[TB] FAIL rst_wrap_cnt: got %0d expected 1", wrap_cnt_o); else passCount++;
    checkCount++; if (duty_ready_o !== 1'b1) $display("[TB] FAIL rst_ready: got %b expected 1", duty_ready_o); else passCount++;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_duty_load();
    test_corner_duties();
    test_seq_err();
    test_saturation();
    test_reset_pending();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
